// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// Handshake: a byte moves on a rising clk edge exactly when in_valid and
// in_ready are both high; the source holds in_data/in_valid stable while
// in_ready is low, and the loader may drop in_ready at any cycle.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              write_en;
  logic [31:0]       data;
  logic [ADDR_W-1:0] addr_wr;

  // Loader side: consumes the stream, drives the memory write port.
  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output write_en,
    output data,
    output addr_wr
  );

  // Environment side: stream source and memory.
  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  write_en,
    input  data,
    input  addr_wr
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: first byte is the word count N (0 means 64),
// then 4*N bytes assembled little-endian into 32-bit words, one write per
// word. The CPU is held for the whole load; done/error are sticky until the
// next start. An idle gap of TIMEOUT_CYC cycles aborts to ERR without
// writing the partial word.
module imem_loader #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                TIMEOUT_CYC = 100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [2:0]    state_dbg
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CNT = 3'd1,
    ST_LOAD     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_idx;
  logic [7:0]        words_left;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              xfer;
  logic              tmo_hit;
  logic              take_start;
  logic              counting;

  assign xfer       = bus.in_valid & bus.in_ready;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign counting   = (state == ST_WAIT_CNT) || (state == ST_LOAD);
  assign take_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

  // Outputs decoded straight from state so reset drops them asynchronously.
  assign bus.in_ready = counting;
  assign bus.write_en = (state == ST_WRITE);
  assign bus.data     = data_q;
  assign bus.addr_wr  = addr_q;
  assign cpu_hold     = (state == ST_WAIT_CNT) || (state == ST_LOAD) || (state == ST_WRITE);
  assign state_dbg    = state;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a byte arriving in the same cycle as a timeout wins.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nx = ST_WAIT_CNT;
      end
      ST_WAIT_CNT: begin
        if (xfer)         state_nx = ST_LOAD;
        else if (tmo_hit) state_nx = ST_ERR;
      end
      ST_LOAD: begin
        if (xfer) begin
          if (byte_idx == 2'd3) state_nx = ST_WRITE;
        end else if (tmo_hit) begin
          state_nx = ST_ERR;
        end
      end
      ST_WRITE: begin
        if (words_left == 8'd1) state_nx = ST_DONE;
        else                    state_nx = ST_LOAD;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Idle-gap counter: cleared on every accepted byte and on any state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (xfer || (state_nx != state)) begin
      tmo_cnt <= '0;
    end else if (counting) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Word assembly, address/word bookkeeping and sticky status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      addr_q     <= BASE_ADDR;
      byte_idx   <= '0;
      words_left <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (take_start) begin
        done     <= 1'b0;
        error    <= 1'b0;
        addr_q   <= BASE_ADDR;
        byte_idx <= '0;
      end
      if (state == ST_WAIT_CNT && xfer) begin
        words_left <= (bus.in_data == 8'd0) ? 8'd64 : bus.in_data;
        byte_idx   <= '0;
      end
      if (state == ST_LOAD && xfer) begin
        data_q[8*byte_idx +: 8] <= bus.in_data;
        byte_idx                <= byte_idx + 2'd1;
      end
      if (state == ST_WRITE) begin
        addr_q     <= addr_q + ADDR_W'(4);
        words_left <= words_left - 8'd1;
        if (words_left == 8'd1) done <= 1'b1;
      end
      if (counting && (state_nx == ST_ERR)) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 00 and base F8)
// share clock and reset; writes are captured from the memory port and
// compared with hand-computed words and addresses.
module tb_imem_loader;

  localparam int TMO = 20;
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_LOAD = 3'd2,
                         S_WRITE = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic       cpu_hold_a, done_a, error_a, cpu_hold_b, done_b, error_b;
  logic [2:0] st_a, st_b;

  int checks = 0;
  int failures = 0;

  logic [31:0] wa_data_q[$];
  logic [7:0]  wa_addr_q[$];
  logic [31:0] wb_data_q[$];
  logic [7:0]  wb_addr_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic        prev_we_a = 1'b0;
  logic        prev_we_b = 1'b0;

  imem_loader_if #(.ADDR_W(8)) bus_a ();
  imem_loader_if #(.ADDR_W(8)) bus_b ();

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00), .TIMEOUT_CYC(TMO)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a), .state_dbg(st_a)
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hF8), .TIMEOUT_CYC(TMO)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b), .state_dbg(st_b)
  );

  // Clock.
  always #5 clk = ~clk;

  // Write capture, plus single-cycle write pulse check.
  always @(negedge clk) begin
    if (bus_a.write_en) begin
      wa_data_q.push_back(bus_a.data);
      wa_addr_q.push_back(bus_a.addr_wr);
      checks++;
      if (prev_we_a) begin failures++; $display("FAIL we_pulse_a write_en=1 two cycles, required single cycle"); end
    end
    if (bus_b.write_en) begin
      wb_data_q.push_back(bus_b.data);
      wb_addr_q.push_back(bus_b.addr_wr);
      checks++;
      if (prev_we_b) begin failures++; $display("FAIL we_pulse_b write_en=1 two cycles, required single cycle"); end
    end
    prev_we_a = bus_a.write_en;
    prev_we_b = bus_b.write_en;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it (bounded).
  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n = 0;
    if (sel) begin bus_b.in_data = b; bus_b.in_valid = 1'b1; end
    else     begin bus_a.in_data = b; bus_a.in_valid = 1'b1; end
    while (!(sel ? bus_b.in_ready : bus_a.in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout sel=%0d byte=%02h in_ready stayed 0, required 1", sel, b);
    end else begin
      @(negedge clk);
    end
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic clear_caps();
    wa_data_q.delete(); wa_addr_q.delete();
    wb_data_q.delete(); wb_addr_q.delete();
    exp_q.delete(); exp_addr_q.delete();
  endtask

  task automatic test_reset();
    // Power-on reset values.
    checks++; if (st_a !== S_IDLE) begin failures++; $display("FAIL por_state got %0d exp %0d", st_a, S_IDLE); end
    checks++; if ({bus_a.in_ready, bus_a.write_en, cpu_hold_a, done_a, error_a} !== 5'b0) begin failures++; $display("FAIL por_flags got %b exp 00000", {bus_a.in_ready, bus_a.write_en, cpu_hold_a, done_a, error_a}); end
    checks++; if (bus_a.data !== 32'h0) begin failures++; $display("FAIL por_data got %08h exp 00000000", bus_a.data); end
    checks++; if (bus_a.addr_wr !== 8'h00) begin failures++; $display("FAIL por_addr_a got %02h exp 00", bus_a.addr_wr); end
    checks++; if (bus_b.addr_wr !== 8'hF8) begin failures++; $display("FAIL por_addr_b got %02h exp f8", bus_b.addr_wr); end
    reset = 1'b1;
    @(negedge clk);
    // Abort in the middle of a write cycle.
    pulse_start(0);
    send_byte(0, 8'h01);
    send_byte(0, 8'h11); send_byte(0, 8'h22); send_byte(0, 8'h33); send_byte(0, 8'h44);
    checks++; if (bus_a.write_en !== 1'b1) begin failures++; $display("FAIL mid_write_en got %b exp 1", bus_a.write_en); end
    checks++; if (bus_a.data !== 32'h44332211) begin failures++; $display("FAIL mid_data got %08h exp 44332211", bus_a.data); end
    #2 reset = 1'b0;
    #1;
    checks++; if (st_a !== S_IDLE) begin failures++; $display("FAIL rst_state got %0d exp %0d", st_a, S_IDLE); end
    checks++; if (bus_a.write_en !== 1'b0) begin failures++; $display("FAIL rst_write_en got %b exp 0", bus_a.write_en); end
    checks++; if ({bus_a.in_ready, cpu_hold_a, done_a, error_a} !== 4'b0) begin failures++; $display("FAIL rst_flags got %b exp 0000", {bus_a.in_ready, cpu_hold_a, done_a, error_a}); end
    checks++; if (bus_a.data !== 32'h0) begin failures++; $display("FAIL rst_data got %08h exp 00000000", bus_a.data); end
    checks++; if (bus_a.addr_wr !== 8'h00) begin failures++; $display("FAIL rst_addr got %02h exp 00", bus_a.addr_wr); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_caps();
  endtask

  task automatic test_two_words();
    logic [7:0] bytes [9] = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    clear_caps();
    pulse_start(0);
    checks++; if (cpu_hold_a !== 1'b1 || st_a !== S_WAIT) begin failures++; $display("FAIL t2_hold got hold=%b st=%0d exp hold=1 st=%0d", cpu_hold_a, st_a, S_WAIT); end
    foreach (bytes[i]) send_byte(0, bytes[i]);
    @(negedge clk);
    checks++; if (done_a !== 1'b1 || cpu_hold_a !== 1'b0) begin failures++; $display("FAIL t2_done got done=%b hold=%b exp done=1 hold=0", done_a, cpu_hold_a); end
    exp_q = '{32'h20000013, 32'hFFFFFFFF};
    exp_addr_q = '{8'h00, 8'h04};
    checks++; if (wa_data_q.size() !== 2) begin failures++; $display("FAIL t2_count got %0d exp 2", wa_data_q.size()); end
    for (int k = 0; k < 2 && k < wa_data_q.size(); k++) begin
      checks++; if (wa_data_q[k] !== exp_q[k] || wa_addr_q[k] !== exp_addr_q[k]) begin failures++; $display("FAIL t2_word%0d got %08h@%02h exp %08h@%02h", k, wa_data_q[k], wa_addr_q[k], exp_q[k], exp_addr_q[k]); end
    end
  endtask

  task automatic test_full_memory();
    clear_caps();
    pulse_start(0);
    send_byte(0, 8'h00);
    for (int i = 0; i < 256; i++) send_byte(0, 8'(i));
    @(negedge clk);
    checks++; if (done_a !== 1'b1 || st_a !== S_DONE) begin failures++; $display("FAIL t3_done got done=%b st=%0d exp 1/%0d", done_a, st_a, S_DONE); end
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
      exp_addr_q.push_back(8'(4*k));
    end
    // A byte offered in DONE must not be consumed or written.
    bus_a.in_data = 8'h5A;
    bus_a.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL t3_ready_done got %b exp 0", bus_a.in_ready); end
    bus_a.in_valid = 1'b0;
    checks++; if (wa_data_q.size() !== 64) begin failures++; $display("FAIL t3_count got %0d exp 64", wa_data_q.size()); end
    for (int k = 0; k < 64 && k < wa_data_q.size(); k++) begin
      checks++; if (wa_data_q[k] !== exp_q[k] || wa_addr_q[k] !== exp_addr_q[k]) begin failures++; $display("FAIL t3_word%0d got %08h@%02h exp %08h@%02h", k, wa_data_q[k], wa_addr_q[k], exp_q[k], exp_addr_q[k]); end
    end
  endtask

  task automatic test_timeout();
    clear_caps();
    pulse_start(0);
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL t4_done_clear got %b exp 0", done_a); end
    send_byte(0, 8'h01);
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    repeat (TMO - 1) @(negedge clk);
    checks++; if (error_a !== 1'b0 || st_a !== S_LOAD) begin failures++; $display("FAIL t4_early got err=%b st=%0d exp 0/%0d", error_a, st_a, S_LOAD); end
    @(negedge clk);
    checks++; if (error_a !== 1'b1 || st_a !== S_ERR || cpu_hold_a !== 1'b0) begin failures++; $display("FAIL t4_err got err=%b st=%0d hold=%b exp 1/%0d/0", error_a, st_a, cpu_hold_a, S_ERR); end
    checks++; if (wa_data_q.size() !== 0) begin failures++; $display("FAIL t4_nowrite got %0d writes exp 0", wa_data_q.size()); end
    pulse_start(0);
    checks++; if (error_a !== 1'b0 || st_a !== S_WAIT) begin failures++; $display("FAIL t4_restart got err=%b st=%0d exp 0/%0d", error_a, st_a, S_WAIT); end
    repeat (TMO + 2) @(negedge clk);
    checks++; if (error_a !== 1'b1 || st_a !== S_ERR) begin failures++; $display("FAIL t4_cnt_tmo got err=%b st=%0d exp 1/%0d", error_a, st_a, S_ERR); end
  endtask

  task automatic test_start_with_valid();
    clear_caps();
    bus_a.in_data = 8'h01;
    bus_a.in_valid = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++; if (st_a !== S_WAIT || error_a !== 1'b0 || bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL sv_wait got st=%0d err=%b rdy=%b exp %0d/0/1", st_a, error_a, bus_a.in_ready, S_WAIT); end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    checks++; if (st_a !== S_LOAD) begin failures++; $display("FAIL sv_load got st=%0d exp %0d", st_a, S_LOAD); end
    send_byte(0, 8'hDE); send_byte(0, 8'hAD); send_byte(0, 8'hBE); send_byte(0, 8'hEF);
    @(negedge clk);
    checks++; if (wa_data_q.size() !== 1) begin failures++; $display("FAIL sv_count got %0d exp 1", wa_data_q.size()); end
    else begin
      checks++; if (wa_data_q[0] !== 32'hEFBEADDE || wa_addr_q[0] !== 8'h00) begin failures++; $display("FAIL sv_word got %08h@%02h exp efbeadde@00", wa_data_q[0], wa_addr_q[0]); end
    end
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL sv_done got %b exp 1", done_a); end
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_caps();
    pulse_start(0);
    send_byte(0, 8'h03);
    for (int i = 0; i < 12; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      send_byte(0, 8'hA0 + 8'(i));
      if (i == 4) begin
        pulse_start(0);
        checks++; if (st_a !== S_LOAD || cpu_hold_a !== 1'b1) begin failures++; $display("FAIL t5_busy_start got st=%0d hold=%b exp %0d/1", st_a, cpu_hold_a, S_LOAD); end
      end
    end
    @(negedge clk);
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL t5_done got %b exp 1", done_a); end
    exp_q = '{32'hA3A2A1A0, 32'hA7A6A5A4, 32'hABAAA9A8};
    exp_addr_q = '{8'h00, 8'h04, 8'h08};
    checks++; if (wa_data_q.size() !== 3) begin failures++; $display("FAIL t5_count got %0d exp 3", wa_data_q.size()); end
    for (int k = 0; k < 3 && k < wa_data_q.size(); k++) begin
      checks++; if (wa_data_q[k] !== exp_q[k] || wa_addr_q[k] !== exp_addr_q[k]) begin failures++; $display("FAIL t5_word%0d got %08h@%02h exp %08h@%02h", k, wa_data_q[k], wa_addr_q[k], exp_q[k], exp_addr_q[k]); end
    end
  endtask

  task automatic test_wrap();
    clear_caps();
    pulse_start(1);
    send_byte(1, 8'h03);
    for (int i = 0; i < 12; i++) send_byte(1, 8'h10 + 8'(i));
    @(negedge clk);
    checks++; if (done_b !== 1'b1 || cpu_hold_b !== 1'b0) begin failures++; $display("FAIL t6_done got done=%b hold=%b exp 1/0", done_b, cpu_hold_b); end
    exp_q = '{32'h13121110, 32'h17161514, 32'h1B1A1918};
    exp_addr_q = '{8'hF8, 8'hFC, 8'h00};
    checks++; if (wb_data_q.size() !== 3) begin failures++; $display("FAIL t6_count got %0d exp 3", wb_data_q.size()); end
    for (int k = 0; k < 3 && k < wb_data_q.size(); k++) begin
      checks++; if (wb_data_q[k] !== exp_q[k] || wb_addr_q[k] !== exp_addr_q[k]) begin failures++; $display("FAIL t6_word%0d got %08h@%02h exp %08h@%02h", k, wb_data_q[k], wb_addr_q[k], exp_q[k], exp_addr_q[k]); end
    end
  endtask

  initial begin
    reset = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.in_data = 8'h00; bus_a.in_valid = 1'b0;
    bus_b.in_data = 8'h00; bus_b.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_two_words();
    test_full_memory();
    test_timeout();
    test_start_with_valid();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
